rob_commit: RTL

In-order retirement buffer (reorder buffer) that produces the register-file write stream for the Tomasulo core. Dispatch allocates one entry per instruction in program order. The common data bus (CDB) fills in results out of order. The head entry drives the register file's single write port (`wr_en`/`wr_addr`/`wr_data`) once its result is present. It also exposes a tag-based result lookup for operand forwarding at dispatch.

---
 rtl/rob_pkg.sv | 15 +
 rtl/rob_commit.sv | 115 +++++++++++
 2 files changed

// File: rtl/rob_pkg.sv
// Shared types and widths for the reorder buffer / in-order retirement block.
package rob_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  // One reorder-buffer slot: occupancy, result-present flag, destination, result.
  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit.sv
// In-order retirement buffer. Dispatch allocates at the tail, the CDB marks
// entries done out of order, and the head drives the register-file write port
// once its result is present. Pointers carry a wrap bit so full/empty fall out
// of a plain compare.
module rob_commit
  import rob_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       alloc_valid,
  input  logic [REG_ADDR_W-1:0]      alloc_rd,
  output logic                       alloc_ready,
  output logic [TAG_W-1:0]           alloc_tag,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [XLEN-1:0]            cdb_data,
  input  logic [TAG_W-1:0]           lookup_tag,
  output logic                       lookup_done,
  output logic [XLEN-1:0]            lookup_data,
  output logic                       rf_wr_en,
  output logic [REG_ADDR_W-1:0]      rf_wr_addr,
  output logic [XLEN-1:0]            rf_wr_data,
  output logic                       commit_valid,
  output logic [TAG_W-1:0]           commit_tag,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = TAG_W + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE = {{TAG_W{1'b0}}, 1'b1};

  rob_entry_t       entries_q [DEPTH];
  rob_entry_t       entries_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;

  logic [TAG_W-1:0] head_idx;
  logic [TAG_W-1:0] tail_idx;
  logic             full;
  rob_entry_t       head_e;
  logic             commit_fire;
  logic             alloc_fire;
  logic [PTR_W-1:0] occupancy;

  assign head_idx  = head_q[TAG_W-1:0];
  assign tail_idx  = tail_q[TAG_W-1:0];
  assign full      = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);
  assign occupancy = tail_q - head_q;
  assign head_e    = entries_q[head_idx];

  // Commit, alloc and lookup outputs: registered state, with flush as the only override.
  always_comb begin
    commit_fire  = head_e.valid && head_e.done && !flush;
    alloc_ready  = !full && !flush;
    alloc_fire   = alloc_valid && alloc_ready;
    alloc_tag    = tail_idx;
    commit_valid = commit_fire;
    commit_tag   = head_idx;
    rf_wr_en     = commit_fire && (head_e.rd != '0);
    rf_wr_addr   = commit_fire ? head_e.rd   : '0;
    rf_wr_data   = commit_fire ? head_e.data : '0;
    lookup_done  = entries_q[lookup_tag].valid && entries_q[lookup_tag].done;
    lookup_data  = entries_q[lookup_tag].data;
    count        = CNT_W'(occupancy);
  end

  // Next state: flush wins; otherwise CDB fill, head pop and tail push apply together.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i].valid = 1'b0;
        entries_d[i].done  = 1'b0;
      end
      head_d = '0;
      tail_d = '0;
    end else begin
      // The CDB write lands after commit was decided on pre-edge done, so a
      // same-tag CDB/commit pair never commits that cycle.
      if (cdb_valid && entries_q[cdb_tag].valid) begin
        entries_d[cdb_tag].done = 1'b1;
        entries_d[cdb_tag].data = cdb_data;
      end
      if (commit_fire) begin
        entries_d[head_idx].valid = 1'b0;
        entries_d[head_idx].done  = 1'b0;
        head_d = head_q + PTR_ONE;
      end
      if (alloc_fire) begin
        entries_d[tail_idx] = '{valid: 1'b1, done: 1'b0, rd: alloc_rd, data: '0};
        tail_d = tail_q + PTR_ONE;
      end
    end
  end

  // State register with synchronous reset that also scrubs entry payloads.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
    end
  end

endmodule
